adc_capture_buf: RTL

- Snapshot buffer that sits directly downstream of the ADC conditioning in pdh_core and consumes its signed 16-bit, offset-removed channel A/B samples.
- On an arm pulse, stores DEPTH sample pairs into block RAM, with optional decimation.
- The PS reads the buffer back one word at a time through the GPIO command path, using an address and a registered read port.
- Gives software a coherent multi-sample view of the error signal, which a single GET_ADC poll cannot provide.

---
 rtl/adc_capture_buf.sv | 123 ++++++++++++
 1 files changed

// File: rtl/adc_capture_buf.sv
// Snapshot buffer: on arm, stores DEPTH {B,A} sample pairs (optionally decimated)
// into a simple-dual-port RAM that software reads back one word at a time.
module adc_capture_buf #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 1024,
    parameter int DECIM_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm_i,
    input  logic [DECIM_WIDTH-1:0]     decim_i,
    input  logic [DATA_WIDTH-1:0]      sample_a_i,
    input  logic [DATA_WIDTH-1:0]      sample_b_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [2*DATA_WIDTH-1:0]    rd_data_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        DONE    = 2'b10
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [AW-1:0]           wr_ptr;
    logic [AW:0]             count;
    logic [DECIM_WIDTH-1:0]  dec_cnt;
    logic [DECIM_WIDTH-1:0]  decim_r;
    logic                    wr_en;
    logic                    last_write;
    logic [2*DATA_WIDTH-1:0] rd_data;
    logic [2*DATA_WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A write that coincides with arm still lands; arm only redirects the next state.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        last_write = 1'b0;
        if (!rst && state == CAPTURE && dec_cnt == '0) begin
            wr_en = 1'b1;
        end
        if (wr_en && wr_ptr == AW'(DEPTH - 1)) begin
            last_write = 1'b1;
        end
        case (state)
            IDLE, DONE: begin
                if (arm_i) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (arm_i) begin
                    state_next = CAPTURE;
                end else if (last_write) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            count   <= '0;
            dec_cnt <= '0;
            decim_r <= '0;
        end else if (arm_i) begin
            wr_ptr  <= '0;
            count   <= '0;
            dec_cnt <= '0;
            decim_r <= decim_i;
        end else if (state == CAPTURE) begin
            if (dec_cnt == decim_r) begin
                dec_cnt <= '0;
            end else begin
                dec_cnt <= dec_cnt + DECIM_WIDTH'(1);
            end
            // The pointer holds at the top address so it never wraps inside a capture.
            if (wr_en) begin
                count <= count + (AW + 1)'(1);
                if (!last_write) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_ptr] <= {sample_b_i, sample_a_i};
        end
    end

    // Non-blocking read of the same array gives read-first behaviour on collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= ram[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data;
    assign busy_o    = (state == CAPTURE);
    assign done_o    = (state == DONE);
    assign count_o   = count;

endmodule
